// File: rtl/dcfifo_pkg.sv
// rtl/dcfifo_pkg.sv - constants and helpers shared by the read- and write-side FIFO controllers.
package dcfifo_pkg;

  localparam int ADDR_W_DEFAULT      = 6;
  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int GRAY_MAX_W          = 32;

  // Pointers carry one extra MSB so that full and empty are distinguishable.
  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/dcfifo_rd_ctrl_if.sv
// rtl/dcfifo_rd_ctrl_if.sv - read-side FIFO control bundle; slave is the controller, master its user.
interface dcfifo_rd_ctrl_if
  import dcfifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
);

  localparam int PTR_W = ptr_w(ADDR_W);

  logic [PTR_W-1:0]  wrptr_gray;
  logic              rdreq;
  logic [ADDR_W-1:0] rdaddr;
  logic              rdvalid;
  logic [PTR_W-1:0]  rdptr_gray;
  logic              rdempty;
  logic [PTR_W-1:0]  rdusedw;
  logic              rdunderflow;

  modport master (
    output wrptr_gray, rdreq,
    input  rdaddr, rdvalid, rdptr_gray, rdempty, rdusedw, rdunderflow
  );

  modport slave (
    input  wrptr_gray, rdreq,
    output rdaddr, rdvalid, rdptr_gray, rdempty, rdusedw, rdunderflow
  );

endinterface

// File: rtl/gray_dec_1p.sv
// rtl/gray_dec_1p.sv - Gray-to-binary decoder with one output register stage.
module gray_dec_1p #(
  parameter int WIDTH = 7
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_q
);

  logic [WIDTH-1:0] bin_d;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_d[i] = ^(gray_in >> i);
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      bin_q <= '0;
    end else begin
      bin_q <= bin_d;
    end
  end

endmodule

// File: rtl/dcfifo_rd_ctrl.sv
// rtl/dcfifo_rd_ctrl.sv - dual-clock FIFO read-side pointer/status controller (read clock domain).
// Optional sticky underflow flag enabled by defining DCFIFO_RD_UNDERFLOW_EN.
module dcfifo_rd_ctrl
  import dcfifo_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic           clock,
  input  logic           aclr,
  dcfifo_rd_ctrl_if.slave bus
);

  localparam int PTR_W = ptr_w(ADDR_W);

  logic [PTR_W-1:0] sync_q [SYNC_STAGES];
  logic [PTR_W-1:0] sync_d [SYNC_STAGES];
  logic [PTR_W-1:0] wbin;

  logic [PTR_W-1:0] rdptr_bin_q,  rdptr_bin_d;
  logic [PTR_W-1:0] rdptr_gray_q, rdptr_gray_d;
  logic [PTR_W-1:0] rdusedw_q,    rdusedw_d;
  logic             rdempty_q,    rdempty_d;
  logic             rdvalid_q,    rdvalid_d;
  logic             accept;
  logic [PTR_W-1:0] rdptr_next;

  always_comb begin
    sync_d[0] = bus.wrptr_gray;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q <= sync_d;
    end
  end

  gray_dec_1p #(
    .WIDTH (PTR_W)
  ) u_gray_dec (
    .clock   (clock),
    .aclr    (aclr),
    .gray_in (sync_q[SYNC_STAGES-1]),
    .bin_q   (wbin)
  );

  // Status looks at the post-accept pointer so the last read raises empty on its own edge.
  always_comb begin
    accept       = bus.rdreq & ~rdempty_q;
    rdptr_next   = rdptr_bin_q + PTR_W'(accept);
    rdptr_bin_d  = rdptr_next;
    rdptr_gray_d = PTR_W'(bin2gray(GRAY_MAX_W'(rdptr_next)));
    rdvalid_d    = accept;
    rdempty_d    = (wbin == rdptr_next);
    rdusedw_d    = wbin - rdptr_next;
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      rdptr_bin_q  <= '0;
      rdptr_gray_q <= '0;
      rdusedw_q    <= '0;
      rdempty_q    <= 1'b1;
      rdvalid_q    <= 1'b0;
    end else begin
      rdptr_bin_q  <= rdptr_bin_d;
      rdptr_gray_q <= rdptr_gray_d;
      rdusedw_q    <= rdusedw_d;
      rdempty_q    <= rdempty_d;
      rdvalid_q    <= rdvalid_d;
    end
  end

`ifdef DCFIFO_RD_UNDERFLOW_EN
  logic rdunderflow_q, rdunderflow_d;

  always_comb begin
    rdunderflow_d = rdunderflow_q | (bus.rdreq & rdempty_q);
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      rdunderflow_q <= 1'b0;
    end else begin
      rdunderflow_q <= rdunderflow_d;
    end
  end

  assign bus.rdunderflow = rdunderflow_q;
`else
  assign bus.rdunderflow = 1'b0;
`endif

  assign bus.rdaddr     = rdptr_bin_q[ADDR_W-1:0];
  assign bus.rdvalid    = rdvalid_q;
  assign bus.rdptr_gray = rdptr_gray_q;
  assign bus.rdempty    = rdempty_q;
  assign bus.rdusedw    = rdusedw_q;

endmodule

// File: tb/tb_dcfifo_rd_ctrl.sv
// tb/tb_dcfifo_rd_ctrl.sv - directed self-checking bench for dcfifo_rd_ctrl (ADDR_W=6, SYNC_STAGES=2).
module tb_dcfifo_rd_ctrl;

  localparam int ADDR_W = 6;
  localparam int PTR_W  = 7;
`ifdef DCFIFO_RD_UNDERFLOW_EN
  localparam logic UF_EN = 1'b1;
`else
  localparam logic UF_EN = 1'b0;
`endif

  logic clock;
  logic aclr;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   nreads, nwr, gray_bad, early_valid;
  logic [PTR_W-1:0] prev_gray;

  dcfifo_rd_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  dcfifo_rd_ctrl #(
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (2)
  ) dut (
    .clock (clock),
    .aclr  (aclr),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PTR_W-1:0] gray7(input int b);
    logic [PTR_W-1:0] v;
    v = PTR_W'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_rdempty"},     bus.rdempty,     1);
    check({pfx, "_rdusedw"},     bus.rdusedw,     0);
    check({pfx, "_rdptr_gray"},  bus.rdptr_gray,  0);
    check({pfx, "_rdvalid"},     bus.rdvalid,     0);
    check({pfx, "_rdaddr"},      bus.rdaddr,      0);
    check({pfx, "_rdunderflow"}, bus.rdunderflow, 0);
  endtask

  task automatic observe_burst();
    if (bus.rdvalid) nreads++;
    check("burst_rdaddr", bus.rdaddr, (1 + nreads) & 63);
    if ($countones(bus.rdptr_gray ^ prev_gray) > 1) gray_bad++;
    prev_gray = bus.rdptr_gray;
    if (nreads > nwr) early_valid++;
  endtask

  initial begin
    aclr           = 1'b1;
    bus.rdreq      = 1'b0;
    bus.wrptr_gray = '0;
    repeat (2) @(posedge clock);
    #2;
    check_reset_outputs("rst");
    aclr = 1'b0;
    tick();

    // rdreq on an empty FIFO is ignored
    bus.rdreq = 1'b1;
    repeat (3) tick();
    check("empty_req_rdaddr",   bus.rdaddr,      0);
    check("empty_req_rdvalid",  bus.rdvalid,     0);
    check("empty_req_rdempty",  bus.rdempty,     1);
    check("empty_req_gray",     bus.rdptr_gray,  0);
    check("empty_req_underflow", bus.rdunderflow, UF_EN);
    bus.rdreq = 1'b0;

    // write arrival latency: status moves on the 4th edge
    bus.wrptr_gray = gray7(1);
    repeat (3) tick();
    check("lat_e3_rdempty", bus.rdempty, 1);
    check("lat_e3_rdusedw", bus.rdusedw, 0);
    tick();
    check("lat_e4_rdempty", bus.rdempty, 0);
    check("lat_e4_rdusedw", bus.rdusedw, 1);

    // single read
    bus.rdreq = 1'b1;
    tick();
    check("rd1_rdvalid", bus.rdvalid,    1);
    check("rd1_rdaddr",  bus.rdaddr,     1);
    check("rd1_rdempty", bus.rdempty,    1);
    check("rd1_rdusedw", bus.rdusedw,    0);
    check("rd1_gray",    bus.rdptr_gray, 1);
    bus.rdreq = 1'b0;
    tick();
    check("rd1_after_rdvalid", bus.rdvalid, 0);
    check("rd1_after_rdaddr",  bus.rdaddr,  1);

    // 200-word streaming burst with wrap of the 7-bit pointer
    nreads = 0; nwr = 0; gray_bad = 0; early_valid = 0;
    prev_gray = bus.rdptr_gray;
    for (int i = 1; i <= 200; i++) begin
      nwr            = i;
      bus.wrptr_gray = gray7(1 + i);
      bus.rdreq      = 1'b1;
      tick();
      observe_burst();
    end
    for (int k = 0; k < 40 && nreads < 200; k++) begin
      tick();
      observe_burst();
    end
    bus.rdreq = 1'b0;
    tick();
    check("burst_nreads",      nreads,          200);
    check("burst_gray_steps",  gray_bad,        0);
    check("burst_early_valid", early_valid,     0);
    check("burst_gray_final",  bus.rdptr_gray,  gray7(201));
    check("burst_rdaddr_final", bus.rdaddr,     9);
    check("burst_rdempty",     bus.rdempty,     1);
    check("burst_rdusedw",     bus.rdusedw,     0);
    check("burst_rdvalid",     bus.rdvalid,     0);
    check("burst_underflow",   bus.rdunderflow, UF_EN);

    // full FIFO from pointer 0
    bus.wrptr_gray = '0;
    #2 aclr = 1'b1;
    #2;
    check("full_rst_underflow", bus.rdunderflow, 0);
    check("full_rst_gray",      bus.rdptr_gray,  0);
    aclr = 1'b0;
    bus.wrptr_gray = gray7(64);
    repeat (5) tick();
    check("full_rdusedw", bus.rdusedw, 64);
    check("full_rdempty", bus.rdempty, 0);
    check("full_rdaddr",  bus.rdaddr,  0);
    bus.rdreq = 1'b1;
    repeat (32) tick();
    check("half_rdusedw", bus.rdusedw,    32);
    check("half_rdaddr",  bus.rdaddr,     32);
    check("half_gray",    bus.rdptr_gray, gray7(32));
    repeat (32) tick();
    bus.rdreq = 1'b0;
    check("drain_rdusedw",   bus.rdusedw,     0);
    check("drain_rdempty",   bus.rdempty,     1);
    check("drain_rdaddr",    bus.rdaddr,      0);
    check("drain_gray",      bus.rdptr_gray,  gray7(64));
    check("drain_rdvalid",   bus.rdvalid,     1);
    check("drain_underflow", bus.rdunderflow, 0);

    // underflow attempt
    bus.rdreq = 1'b1;
    tick();
    bus.rdreq = 1'b0;
    check("uf_rdvalid",   bus.rdvalid,     0);
    check("uf_rdaddr",    bus.rdaddr,      0);
    check("uf_gray",      bus.rdptr_gray,  gray7(64));
    check("uf_flag",      bus.rdunderflow, UF_EN);
    tick();
    check("uf_sticky",    bus.rdunderflow, UF_EN);

    // asynchronous reset in the middle of a burst
    bus.wrptr_gray = '0;
    #2 aclr = 1'b1;
    #2 aclr = 1'b0;
    bus.wrptr_gray = gray7(12);
    repeat (5) tick();
    check("mid_pre_rdusedw", bus.rdusedw, 12);
    bus.rdreq = 1'b1;
    repeat (2) tick();
    check("mid_busy_rdusedw", bus.rdusedw, 10);
    check("mid_busy_rdaddr",  bus.rdaddr,  2);
    check("mid_busy_rdvalid", bus.rdvalid, 1);
    #2 aclr = 1'b1;
    #1;
    check_reset_outputs("mid");
    bus.rdreq      = 1'b0;
    bus.wrptr_gray = '0;
    @(posedge clock);
    #3 aclr = 1'b0;
    bus.wrptr_gray = gray7(1);
    repeat (4) tick();
    check("restart_rdempty", bus.rdempty, 0);
    check("restart_rdusedw", bus.rdusedw, 1);
    bus.rdreq = 1'b1;
    tick();
    bus.rdreq = 1'b0;
    check("restart_rdaddr",  bus.rdaddr,     1);
    check("restart_rdvalid", bus.rdvalid,    1);
    check("restart_gray",    bus.rdptr_gray, 1);
    check("restart_rdempty_after", bus.rdempty, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
